// File: rtl/cu_gen2.sv
// cu_gen2: multi-cycle control unit for the mycpu datapath.
// Decodes the opcode held in the instruction register and drives the PC select,
// register-file, ALU, memory and IO controls. Beyond the basic fetch/execute loop it
// provides an IO request/acknowledge handshake with timeout, a bounded XXL shift
// loop and a HLT state that resumes on run_in.
// Opcode map (OPC_W bits): 0..15 ALU ops (fs = opcode[3:0]), 16 LDI, 17 ADI, 18 LD,
// 19 ST, 20 BRZ, 21 BRN, 22 JMP, 23 IOR, 24 IOW, 25 XXL, 26 HAL; all others undefined.
module cu_gen2 #(
  parameter int IW      = 16,
  parameter int OPC_W   = 7,
  parameter int RF_AW   = 4,
  parameter int XXL_MAX = 16,
  parameter int IO_TMO  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IW-1:0]      ins_in,
  input  logic               z_in,
  input  logic               n_in,
  input  logic               io_ack_in,
  input  logic               run_in,
  output logic               il_out,
  output logic [1:0]         ps_out,
  output logic               rw_out,
  output logic [3*RF_AW-1:0] rs_out,
  output logic               mm_out,
  output logic [1:0]         md_out,
  output logic               mb_out,
  output logic [3:0]         fs_out,
  output logic               wen_out,
  output logic               iom_out,
  output logic               io_req_out,
  output logic               halted_out,
  output logic               err_out
);

  localparam int FW = (IW - OPC_W) / 3;
  localparam int CW = $clog2(XXL_MAX + 1);
  localparam int TW = $clog2(IO_TMO + 1);

  localparam logic [OPC_W-1:0] OP_ALU_END = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_LDI     = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_ADI     = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_LD      = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_ST      = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_BRZ     = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_BRN     = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_JMP     = OPC_W'(22);
  localparam logic [OPC_W-1:0] OP_IOR     = OPC_W'(23);
  localparam logic [OPC_W-1:0] OP_IOW     = OPC_W'(24);
  localparam logic [OPC_W-1:0] OP_XXL     = OPC_W'(25);
  localparam logic [OPC_W-1:0] OP_HAL     = OPC_W'(26);

  typedef enum logic [2:0] {
    S_RST,
    S_INF,
    S_EX0,
    S_XL1,
    S_IOWT,
    S_HLT
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [TW-1:0]     tmo, tmo_nx;

  logic [OPC_W-1:0]  opcode;
  logic [FW-1:0]     fld_d, fld_a, fld_b;
  logic [3*RF_AW-1:0] rs_fields;
  logic              is_alu;
  logic              is_ior;

  assign opcode    = ins_in[IW-1 -: OPC_W];
  assign fld_d     = ins_in[3*FW-1:2*FW];
  assign fld_a     = ins_in[2*FW-1:FW];
  assign fld_b     = ins_in[FW-1:0];
  assign rs_fields = {RF_AW'(fld_d), RF_AW'(fld_a), RF_AW'(fld_b)};
  assign is_alu    = (opcode < OP_ALU_END);
  assign is_ior    = (opcode == OP_IOR);

  // Decode state, opcode and flags into datapath controls and the next state/counter values
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tmo_nx     = tmo;
    il_out     = 1'b0;
    ps_out     = 2'b00;
    rw_out     = 1'b0;
    rs_out     = '0;
    mm_out     = 1'b0;
    md_out     = 2'b00;
    mb_out     = 1'b0;
    fs_out     = 4'b0000;
    wen_out    = 1'b1;
    iom_out    = 1'b0;
    io_req_out = 1'b0;
    halted_out = 1'b0;
    err_out    = 1'b0;

    unique case (state)
      S_RST: begin
        state_nx = S_INF;
      end

      S_INF: begin
        il_out   = 1'b1;
        mm_out   = 1'b1;
        state_nx = S_EX0;
      end

      S_EX0: begin
        ps_out   = 2'b01;
        rs_out   = rs_fields;
        state_nx = S_INF;
        if (is_alu) begin
          rw_out = 1'b1;
          fs_out = opcode[3:0];
        end else begin
          case (opcode)
            OP_LDI: begin
              rw_out = 1'b1;
              mb_out = 1'b1;
              fs_out = 4'b1100;
            end
            OP_ADI: begin
              rw_out = 1'b1;
              mb_out = 1'b1;
              fs_out = 4'b0010;
            end
            OP_LD: begin
              rw_out = 1'b1;
              md_out = 2'b01;
            end
            OP_ST: begin
              wen_out = 1'b0;
            end
            OP_BRZ: begin
              ps_out = z_in ? 2'b10 : 2'b01;
            end
            OP_BRN: begin
              ps_out = n_in ? 2'b10 : 2'b01;
            end
            OP_JMP: begin
              ps_out = 2'b11;
            end
            OP_IOR, OP_IOW: begin
              iom_out    = 1'b1;
              io_req_out = 1'b1;
              if (io_ack_in) begin
                if (is_ior) begin
                  rw_out = 1'b1;
                  md_out = 2'b10;
                end
              end else begin
                ps_out   = 2'b00;
                tmo_nx   = TW'(1);
                state_nx = S_IOWT;
              end
            end
            OP_XXL: begin
              rw_out  = 1'b1;
              iom_out = 1'b1;
              fs_out  = 4'b1110;
              rs_out  = '0;
              ps_out  = 2'b00;
              if (z_in || (cnt == CW'(XXL_MAX - 1))) begin
                cnt_nx = '0;
              end else begin
                cnt_nx   = cnt + CW'(1);
                state_nx = S_XL1;
              end
            end
            OP_HAL: begin
              ps_out   = 2'b00;
              state_nx = S_HLT;
            end
            default: begin
              err_out = 1'b1;
            end
          endcase
        end
      end

      S_XL1: begin
        rs_out  = {RF_AW'(1), RF_AW'(0), RF_AW'(0)};
        fs_out  = 4'b1110;
        iom_out = 1'b1;
        wen_out = 1'b0;
        ps_out  = 2'b00;
        if (z_in) begin
          cnt_nx   = '0;
          state_nx = S_INF;
        end else begin
          state_nx = S_EX0;
        end
      end

      S_IOWT: begin
        iom_out    = 1'b1;
        io_req_out = 1'b1;
        rs_out     = rs_fields;
        ps_out     = 2'b00;
        if (io_ack_in) begin
          ps_out   = 2'b01;
          tmo_nx   = '0;
          state_nx = S_INF;
          if (is_ior) begin
            rw_out = 1'b1;
            md_out = 2'b10;
          end
        end else if (tmo == TW'(IO_TMO)) begin
          ps_out   = 2'b01;
          err_out  = 1'b1;
          tmo_nx   = '0;
          state_nx = S_INF;
        end else begin
          tmo_nx = tmo + TW'(1);
        end
      end

      S_HLT: begin
        halted_out = 1'b1;
        if (run_in) begin
          state_nx = S_INF;
        end
      end

      default: begin
        state_nx = S_RST;
      end
    endcase
  end

  // State and loop/timeout counters; reset abandons any IO wait or XXL loop at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tmo   <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_cu_gen2.sv
// tb_cu_gen2: directed and randomized instruction streams for cu_gen2. A per-instruction
// reference model expands each instruction into the expected cycle-by-cycle control
// vectors, which are queued and compared against the DUT outputs.
module tb_cu_gen2;

  localparam int IW      = 16;
  localparam int OPC_W   = 7;
  localparam int RF_AW   = 4;
  localparam int XXL_MAX = 16;
  localparam int IO_TMO  = 8;
  localparam int VW      = 29;

  localparam logic [6:0] OP_ADD = 7'd2;
  localparam logic [6:0] OP_LDI = 7'd16;
  localparam logic [6:0] OP_ADI = 7'd17;
  localparam logic [6:0] OP_LD  = 7'd18;
  localparam logic [6:0] OP_ST  = 7'd19;
  localparam logic [6:0] OP_BRZ = 7'd20;
  localparam logic [6:0] OP_BRN = 7'd21;
  localparam logic [6:0] OP_JMP = 7'd22;
  localparam logic [6:0] OP_IOR = 7'd23;
  localparam logic [6:0] OP_IOW = 7'd24;
  localparam logic [6:0] OP_XXL = 7'd25;
  localparam logic [6:0] OP_HAL = 7'd26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IW-1:0] ins_in;
  logic z_in, n_in, io_ack_in, run_in;
  logic il_out, rw_out, mm_out, mb_out, wen_out, iom_out, io_req_out, halted_out, err_out;
  logic [1:0] ps_out, md_out;
  logic [3:0] fs_out;
  logic [3*RF_AW-1:0] rs_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic [IW-1:0] ins;
    logic          z, n, ack, run;
    logic [VW-1:0] exp;
    logic [VW-1:0] mask;
    string         tag;
  } cyc_t;

  cyc_t q[$];

  cu_gen2 #(.IW(IW), .OPC_W(OPC_W), .RF_AW(RF_AW), .XXL_MAX(XXL_MAX), .IO_TMO(IO_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .z_in(z_in), .n_in(n_in),
    .io_ack_in(io_ack_in), .run_in(run_in), .il_out(il_out), .ps_out(ps_out),
    .rw_out(rw_out), .rs_out(rs_out), .mm_out(mm_out), .md_out(md_out), .mb_out(mb_out),
    .fs_out(fs_out), .wen_out(wen_out), .iom_out(iom_out), .io_req_out(io_req_out),
    .halted_out(halted_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  // Control vector layout: il, ps, rw, rs, mm, md, mb, fs, wen, iom, io_req, halted, err
  function automatic logic [VW-1:0] vec(input logic il, input logic [1:0] ps, input logic rw,
                                        input logic [11:0] rs, input logic mm, input logic [1:0] md,
                                        input logic mb, input logic [3:0] fs, input logic wen,
                                        input logic iom, input logic req, input logic hlt,
                                        input logic err);
    return {il, ps, rw, rs, mm, md, mb, fs, wen, iom, req, hlt, err};
  endfunction

  function automatic logic [VW-1:0] vec_rst();
    return vec(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] e, input logic [VW-1:0] m);
    logic [VW-1:0] obs;
    obs = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
           wen_out, iom_out, io_req_out, halted_out, err_out};
    checks++;
    assert ((obs & m) === (e & m)) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs & m, e & m);
    end
  endtask

  task automatic push(input logic [IW-1:0] ins, input logic z, input logic n, input logic ack,
                      input logic run, input logic [VW-1:0] e, input logic rw_dc, input string tag);
    cyc_t c;
    c.ins  = ins;
    c.z    = z;
    c.n    = n;
    c.ack  = ack;
    c.run  = run;
    c.exp  = e;
    c.mask = rw_dc ? ~(VW'(1) << 25) : '1;
    c.tag  = tag;
    q.push_back(c);
  endtask

  // Reference model: one fetch cycle plus the execute cycles implied by the instruction's rules
  task automatic add_instr(input logic [6:0] opc, input logic [2:0] d, input logic [2:0] a,
                           input logic [2:0] b, input int ack_wait, input int z_iter,
                           input int halt_cycles, input int flag);
    logic [IW-1:0] ins;
    logic [11:0]   rs;
    logic          f, isr;
    ins = {opc, d, a, b};
    rs  = {1'b0, d, 1'b0, a, 1'b0, b};
    isr = (opc == OP_IOR);
    f   = (flag < 0) ? 1'($urandom_range(0, 1)) : 1'(flag);
    push(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
         vec(1, 2'd0, 0, 12'h0, 1, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "INF");
    if (opc < 7'd16) begin
      push(ins, 0, 0, 0, 0, vec(0, 2'd1, 1, rs, 0, 2'd0, 0, opc[3:0], 1, 0, 0, 0, 0), 1'b0, "ALU");
    end else begin
      case (opc)
        OP_LDI: push(ins, 0, 0, 0, 0, vec(0, 2'd1, 1, rs, 0, 2'd0, 1, 4'hC, 1, 0, 0, 0, 0), 1'b0, "LDI");
        OP_ADI: push(ins, 0, 0, 0, 0, vec(0, 2'd1, 1, rs, 0, 2'd0, 1, 4'h2, 1, 0, 0, 0, 0), 1'b0, "ADI");
        OP_LD:  push(ins, 0, 0, 0, 0, vec(0, 2'd1, 1, rs, 0, 2'd1, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "LD");
        OP_ST:  push(ins, 0, 0, 0, 0, vec(0, 2'd1, 0, rs, 0, 2'd0, 0, 4'h0, 0, 0, 0, 0, 0), 1'b0, "ST");
        OP_BRZ: push(ins, f, ~f, 0, 0, vec(0, f ? 2'd2 : 2'd1, 0, rs, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "BRZ");
        OP_BRN: push(ins, ~f, f, 0, 0, vec(0, f ? 2'd2 : 2'd1, 0, rs, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "BRN");
        OP_JMP: push(ins, 0, 0, 0, 0, vec(0, 2'd3, 0, rs, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "JMP");
        OP_IOR, OP_IOW: begin
          if (ack_wait == 0) begin
            push(ins, 0, 0, 1, 0, vec(0, 2'd1, isr, rs, 0, isr ? 2'd2 : 2'd0, 0, 4'h0, 1, 1, 1, 0, 0), 1'b0, "IO_FAST");
          end else begin
            push(ins, 0, 0, 0, 0, vec(0, 2'd0, 0, rs, 0, 2'd0, 0, 4'h0, 1, 1, 1, 0, 0), 1'b0, "IO_REQ");
            for (int k = 1; k <= IO_TMO; k++) begin
              if (k == ack_wait) begin
                push(ins, 0, 0, 1, 0, vec(0, 2'd1, isr, rs, 0, isr ? 2'd2 : 2'd0, 0, 4'h0, 1, 1, 1, 0, 0), 1'b0, "IO_ACK");
                break;
              end else if (k == IO_TMO) begin
                push(ins, 0, 0, 0, 0, vec(0, 2'd1, 0, rs, 0, 2'd0, 0, 4'h0, 1, 1, 1, 0, 1), 1'b0, "IO_TMO");
              end else begin
                push(ins, 0, 0, 0, 0, vec(0, 2'd0, 0, rs, 0, 2'd0, 0, 4'h0, 1, 1, 1, 0, 0), 1'b0, "IO_WAIT");
              end
            end
          end
        end
        OP_XXL: begin
          for (int i = 0; i < XXL_MAX; i++) begin
            push(ins, 0, 0, 0, 0, vec(0, 2'd0, 1, 12'h000, 0, 2'd0, 0, 4'hE, 1, 1, 0, 0, 0), 1'b0, "XXL_EX0");
            if (i == XXL_MAX - 1) break;
            f = ((i + 1) == z_iter);
            push(ins, f, 0, 0, 0, vec(0, 2'd0, 0, 12'h100, 0, 2'd0, 0, 4'hE, 0, 1, 0, 0, 0), 1'b1, "XXL_XL1");
            if (f) break;
          end
        end
        OP_HAL: begin
          push(ins, 0, 0, 0, 0, vec(0, 2'd0, 0, rs, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 0), 1'b0, "HAL");
          repeat (halt_cycles)
            push(ins, 0, 0, 0, 0, vec(0, 2'd0, 0, 12'h0, 0, 2'd0, 0, 4'h0, 1, 0, 0, 1, 0), 1'b0, "HLT");
          push(ins, 0, 0, 0, 1, vec(0, 2'd0, 0, 12'h0, 0, 2'd0, 0, 4'h0, 1, 0, 0, 1, 0), 1'b0, "HLT_RUN");
        end
        default: push(ins, 0, 0, 0, 0, vec(0, 2'd1, 0, rs, 0, 2'd0, 0, 4'h0, 1, 0, 0, 0, 1), 1'b0, "UNDEF");
      endcase
    end
  endtask

  // Drive each queued cycle just after the falling edge and compare before the rising edge
  task automatic run_q(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      ins_in    = c.ins;
      z_in      = c.z;
      n_in      = c.n;
      io_ack_in = c.ack;
      run_in    = c.run;
      #1;
      check(c.tag, c.exp, c.mask);
      @(negedge clk);
    end
  endtask

  task automatic run_all();
    run_q(q.size());
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check(tag, vec_rst(), '1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push(ins_in, 0, 0, 0, 0, vec_rst(), 1'b0, "RST");
  endtask

  initial begin
    logic [6:0] opc;
    ins_in    = '0;
    z_in      = 1'b0;
    n_in      = 1'b0;
    io_ack_in = 1'b0;
    run_in    = 1'b0;
    rst_n     = 1'b0;

    @(negedge clk);
    #1;
    check("RESET_HOLD", vec_rst(), '1);
    @(negedge clk);
    rst_n = 1'b1;
    push('0, 0, 0, 0, 0, vec_rst(), 1'b0, "RST");

    add_instr(OP_ADD, 3'd2, 3'd3, 3'd4, 0, 0, 0, -1);
    add_instr(OP_BRZ, 3'd1, 3'd0, 3'd5, 0, 0, 0, 1);
    add_instr(OP_BRZ, 3'd1, 3'd0, 3'd5, 0, 0, 0, 0);
    add_instr(OP_BRN, 3'd0, 3'd6, 3'd1, 0, 0, 0, 1);
    add_instr(OP_JMP, 3'd7, 3'd2, 3'd2, 0, 0, 0, -1);
    add_instr(OP_LDI, 3'd5, 3'd0, 3'd7, 0, 0, 0, -1);
    add_instr(OP_ADI, 3'd1, 3'd1, 3'd3, 0, 0, 0, -1);
    add_instr(OP_LD,  3'd4, 3'd2, 3'd0, 0, 0, 0, -1);
    add_instr(OP_ST,  3'd0, 3'd3, 3'd6, 0, 0, 0, -1);
    add_instr(OP_IOR, 3'd6, 3'd1, 3'd2, 4, 0, 0, -1);
    add_instr(OP_IOR, 3'd3, 3'd3, 3'd3, 99, 0, 0, -1);
    add_instr(OP_IOW, 3'd2, 3'd5, 3'd1, 0, 0, 0, -1);
    add_instr(OP_IOW, 3'd2, 3'd5, 3'd1, IO_TMO, 0, 0, -1);
    add_instr(OP_HAL, 3'd0, 3'd0, 3'd0, 0, 0, 20, -1);
    add_instr(7'h7F,  3'd1, 3'd2, 3'd3, 0, 0, 0, -1);
    add_instr(OP_XXL, 3'd0, 3'd0, 3'd0, 0, 0, 0, -1);
    add_instr(OP_ADD, 3'd7, 3'd7, 3'd7, 0, 0, 0, -1);
    run_all();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) opc = 7'($urandom_range(0, 26));
      else                          opc = 7'($urandom_range(27, 127));
      add_instr(opc, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 10), 0, $urandom_range(0, 4), -1);
      run_all();
    end

    add_instr(OP_XXL, 3'd0, 3'd0, 3'd0, 0, 2, 0, -1);
    run_all();

    add_instr(OP_IOR, 3'd1, 3'd2, 3'd3, 99, 0, 0, -1);
    run_q(4);
    async_reset("RST_MID_IOWT");
    add_instr(OP_XXL, 3'd0, 3'd0, 3'd0, 0, 0, 0, -1);
    run_q(8);
    async_reset("RST_MID_XXL");
    add_instr(OP_XXL, 3'd0, 3'd0, 3'd0, 0, 0, 0, -1);
    add_instr(OP_ADD, 3'd2, 3'd3, 3'd4, 0, 0, 0, -1);
    run_all();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
